// File: rtl/tc_sram_arb.sv
// tc_sram_arb: per-bank round-robin scheduler in front of the banked tensor-core SRAM.
// Each bank takes one write and two reads (ports A/B) per cycle. Read data comes back
// through a fixed-latency pipe that tags every granted read with its bank and port.
module tc_sram_arb #(
  parameter int NumReq       = 4,
  parameter int NumBanks     = 4,
  parameter int WordsPerBank = 256,
  parameter int DataWidth    = 32,
  parameter int RdLatency    = 1,
  parameter int BankBits     = $clog2(NumBanks),
  parameter int AddrWidth    = $clog2(WordsPerBank),
  parameter int ReqAddrWidth = AddrWidth + BankBits
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NumReq-1:0]       req_valid,
  output logic [NumReq-1:0]       req_ready,
  input  logic [NumReq-1:0]       req_we,
  input  logic [ReqAddrWidth-1:0] req_addr    [NumReq],
  input  logic [DataWidth-1:0]    req_wdata   [NumReq],
  output logic [NumReq-1:0]       rsp_valid,
  output logic [DataWidth-1:0]    rsp_data    [NumReq],
  output logic [NumBanks-1:0]     sram_we,
  output logic [NumBanks-1:0]     sram_re,
  output logic [AddrWidth-1:0]    sram_waddr  [NumBanks],
  output logic [AddrWidth-1:0]    sram_raddr1 [NumBanks],
  output logic [AddrWidth-1:0]    sram_raddr2 [NumBanks],
  output logic [DataWidth-1:0]    sram_wdata  [NumBanks],
  input  logic [DataWidth-1:0]    sram_rdataA [NumBanks],
  input  logic [DataWidth-1:0]    sram_rdataB [NumBanks]
);

  localparam int ReqIdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [BankBits-1:0]  req_bank_s  [NumReq];
  logic [AddrWidth-1:0] req_word_s  [NumReq];
  logic [NumReq-1:0]    wr_gnt_s;
  logic [NumReq-1:0]    rd_gnt_s;
  logic [NumReq-1:0]    rd_port_s;    // 1 = read granted on port B
  logic [ReqIdxW-1:0]   ptr_r       [NumBanks];
  logic [ReqIdxW-1:0]   ptr_nxt_s   [NumBanks];
  logic [NumBanks-1:0]  ptr_upd_s;

  logic [NumReq-1:0]    pipe_vld_r  [RdLatency];
  logic [NumReq-1:0]    pipe_port_r [RdLatency];
  logic [BankBits-1:0]  pipe_bank_r [RdLatency][NumReq];

  // Split each flat address into bank select (low bits) and in-bank word.
  always_comb begin
    for (int r = 0; r < NumReq; r++) begin
      req_bank_s[r] = req_addr[r][BankBits-1:0];
      req_word_s[r] = req_addr[r][ReqAddrWidth-1:BankBits];
    end
  end

  // Per-bank arbitration: rotate from ptr, pick one write then up to two non-conflicting reads.
  always_comb begin : grant
    logic [ReqIdxW-1:0]   idx_s;
    logic [ReqIdxW-1:0]   last_s;
    logic                 any_s;
    logic                 wr_hit_s;
    logic [AddrWidth-1:0] wr_word_s;
    logic [1:0]           rd_cnt_s;
    wr_gnt_s  = '0;
    rd_gnt_s  = '0;
    rd_port_s = '0;
    sram_we   = '0;
    sram_re   = '0;
    ptr_upd_s = '0;
    idx_s     = '0;
    last_s    = '0;
    any_s     = 1'b0;
    wr_hit_s  = 1'b0;
    wr_word_s = '0;
    rd_cnt_s  = 2'd0;
    for (int b = 0; b < NumBanks; b++) begin
      sram_waddr[b]  = '0;
      sram_raddr1[b] = '0;
      sram_raddr2[b] = '0;
      sram_wdata[b]  = '0;
      ptr_nxt_s[b]   = ptr_r[b];
    end
    for (int b = 0; b < NumBanks; b++) begin
      wr_hit_s  = 1'b0;
      wr_word_s = '0;
      rd_cnt_s  = 2'd0;
      any_s     = 1'b0;
      last_s    = ptr_r[b];
      // write slot: first writer in scan order
      for (int k = 0; k < NumReq; k++) begin
        idx_s = ReqIdxW'((int'(ptr_r[b]) + k) % NumReq);
        if (!rst && !wr_hit_s && req_valid[idx_s] && req_we[idx_s] &&
            (req_bank_s[idx_s] == BankBits'(b))) begin
          wr_hit_s        = 1'b1;
          wr_word_s       = req_word_s[idx_s];
          wr_gnt_s[idx_s] = 1'b1;
          sram_we[b]      = 1'b1;
          sram_waddr[b]   = req_word_s[idx_s];
          sram_wdata[b]   = req_wdata[idx_s];
        end else begin
          wr_hit_s = wr_hit_s;
        end
      end
      // read slots: first two readers not colliding with the granted write word
      for (int k = 0; k < NumReq; k++) begin
        idx_s = ReqIdxW'((int'(ptr_r[b]) + k) % NumReq);
        if (!rst && req_valid[idx_s] && !req_we[idx_s] &&
            (req_bank_s[idx_s] == BankBits'(b)) && (rd_cnt_s < 2'd2) &&
            !(wr_hit_s && (req_word_s[idx_s] == wr_word_s))) begin
          rd_gnt_s[idx_s] = 1'b1;
          sram_re[b]      = 1'b1;
          if (rd_cnt_s == 2'd0) begin
            sram_raddr1[b] = req_word_s[idx_s];
          end else begin
            sram_raddr2[b]   = req_word_s[idx_s];
            rd_port_s[idx_s] = 1'b1;
          end
          rd_cnt_s = rd_cnt_s + 2'd1;
        end else begin
          rd_cnt_s = rd_cnt_s;
        end
      end
      // pointer moves past the last granted requester in scan order
      for (int k = 0; k < NumReq; k++) begin
        idx_s = ReqIdxW'((int'(ptr_r[b]) + k) % NumReq);
        if ((wr_gnt_s[idx_s] || rd_gnt_s[idx_s]) && (req_bank_s[idx_s] == BankBits'(b))) begin
          any_s  = 1'b1;
          last_s = idx_s;
        end else begin
          any_s = any_s;
        end
      end
      ptr_upd_s[b] = any_s;
      ptr_nxt_s[b] = ReqIdxW'((int'(last_s) + 1) % NumReq);
    end
  end

  assign req_ready = wr_gnt_s | rd_gnt_s;

  // Round-robin pointer per bank; only advances when the bank granted something.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NumBanks; b++) ptr_r[b] <= '0;
    end else begin
      for (int b = 0; b < NumBanks; b++) begin
        if (ptr_upd_s[b]) ptr_r[b] <= ptr_nxt_s[b];
      end
    end
  end

  // Read-return tag pipe matching the SRAM read latency; reset drops in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < RdLatency; s++) begin
        pipe_vld_r[s]  <= '0;
        pipe_port_r[s] <= '0;
        for (int r = 0; r < NumReq; r++) pipe_bank_r[s][r] <= '0;
      end
    end else begin
      pipe_vld_r[0]  <= rd_gnt_s;
      pipe_port_r[0] <= rd_port_s;
      for (int r = 0; r < NumReq; r++) pipe_bank_r[0][r] <= req_bank_s[r];
      for (int s = 1; s < RdLatency; s++) begin
        pipe_vld_r[s]  <= pipe_vld_r[s-1];
        pipe_port_r[s] <= pipe_port_r[s-1];
        for (int r = 0; r < NumReq; r++) pipe_bank_r[s][r] <= pipe_bank_r[s-1][r];
      end
    end
  end

  // Registered response: steer the tagged bank/port data to its requester, zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      for (int r = 0; r < NumReq; r++) rsp_data[r] <= '0;
    end else begin
      for (int r = 0; r < NumReq; r++) begin
        if (pipe_vld_r[RdLatency-1][r]) begin
          rsp_valid[r] <= 1'b1;
          rsp_data[r]  <= pipe_port_r[RdLatency-1][r] ? sram_rdataB[pipe_bank_r[RdLatency-1][r]]
                                                      : sram_rdataA[pipe_bank_r[RdLatency-1][r]];
        end else begin
          rsp_valid[r] <= 1'b0;
          rsp_data[r]  <= '0;
        end
      end
    end
  end

endmodule
